// File: rtl/layer_mvm_par.sv
// Fully-connected layer engine: y = act(W*x + b) over valid/ready streams, P MAC lanes.
// Coefficients live in a run-time-writable register file; x/y buffers are not reset.

module layer_mvm_lane #(
    parameter int T    = 12,
    parameter int N    = 8,
    parameter int RELU = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                preload,
    input  logic                acc_en,
    input  logic signed [T-1:0] w,
    input  logic signed [T-1:0] x,
    input  logic signed [T-1:0] b,
    output logic        [T-1:0] y
);
    localparam int PW = 2 * T;
    localparam int AW = 2 * T + $clog2(N) + 1;
    localparam logic signed [AW-1:0] YMAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

    logic signed [PW-1:0] prod_q, prod_d;
    logic signed [AW-1:0] acc_q, acc_d;

    // The product register runs freely; the accumulator consumes it one cycle later.
    always_comb begin
        prod_d = PW'(w) * PW'(x);
        acc_d  = acc_q;
        if (preload)
            acc_d = AW'(b);
        else if (acc_en)
            acc_d = acc_q + AW'(prod_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

    always_comb begin
        if (acc_q > YMAX)
            y = YMAX[T-1:0];
        else if (acc_q < YMIN)
            y = YMIN[T-1:0];
        else
            y = acc_q[T-1:0];
        if (RELU != 0 && y[T-1])
            y = '0;
    end
endmodule

module layer_mvm_par #(
    parameter int N    = 8,
    parameter int M    = 8,
    parameter int T    = 12,
    parameter int P    = 2,
    parameter int RELU = 1,
    parameter int CAW  = $clog2(M*N+M)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [T-1:0]   data_in,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [T-1:0]   data_out,
    input  logic           cfg_we,
    input  logic [CAW-1:0] cfg_addr,
    input  logic [T-1:0]   cfg_data,
    output logic           busy
);
    localparam int G     = M / P;
    localparam int NCOEF = M * N + M;
    localparam int SW    = $clog2(N + 2);
    localparam int NW    = (N > 1) ? $clog2(N) : 1;
    localparam int MW    = (M > 1) ? $clog2(M) : 1;
    localparam int GW    = (G > 1) ? $clog2(G) : 1;

    localparam logic [SW-1:0] STEP_N    = SW'(N);
    localparam logic [SW-1:0] STEP_LAST = SW'(N + 1);
    localparam logic [NW-1:0] IN_LAST   = NW'(N - 1);
    localparam logic [MW-1:0] OUT_LAST  = MW'(M - 1);
    localparam logic [GW-1:0] GRP_LAST  = GW'(G - 1);
    localparam logic [CAW:0]  NCOEF_W   = (CAW+1)'(NCOEF);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [NW-1:0]  in_cnt_q, in_cnt_d;
    logic [SW-1:0]  step_q, step_d;
    logic [GW-1:0]  grp_q, grp_d;
    logic [MW-1:0]  out_cnt_q, out_cnt_d;
    logic           s_ready_q, s_ready_d;
    logic           m_valid_q, m_valid_d;
    logic [T-1:0]   data_out_q, data_out_d;
    logic           busy_q, busy_d;

    logic [T-1:0]   coef_mem [NCOEF];
    logic [T-1:0]   x_mem    [N];
    logic [T-1:0]   y_mem    [M];

    logic [NW-1:0]          col;
    logic [T-1:0]           x_sel;
    logic                   preload, acc_en, wr_rows;
    logic [P-1:0][T-1:0]    lane_y;
    logic [P-1:0][MW-1:0]   row_idx;
    logic [MW-1:0]          out_nxt;

    // Column index stays in range during the two tail steps of a group.
    always_comb begin
        col     = (step_q < STEP_N) ? step_q[NW-1:0] : '0;
        x_sel   = x_mem[col];
        preload = (state_q == S_COMPUTE) && (step_q == '0);
        acc_en  = (state_q == S_COMPUTE) && (step_q != '0) && (step_q <= STEP_N);
        wr_rows = (state_q == S_COMPUTE) && (step_q == STEP_LAST);
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        logic [CAW-1:0] row;
        logic [T-1:0]   w_k, b_k;

        assign row        = CAW'(grp_q) * CAW'(P) + CAW'(k);
        assign w_k        = coef_mem[row * CAW'(N) + CAW'(col)];
        assign b_k        = coef_mem[CAW'(M * N) + row];
        assign row_idx[k] = row[MW-1:0];

        layer_mvm_lane #(.T(T), .N(N), .RELU(RELU)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .preload (preload),
            .acc_en  (acc_en),
            .w       (w_k),
            .x       (x_sel),
            .b       (b_k),
            .y       (lane_y[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        in_cnt_d   = in_cnt_q;
        step_d     = step_q;
        grp_d      = grp_q;
        out_cnt_d  = out_cnt_q;
        s_ready_d  = s_ready_q;
        m_valid_d  = m_valid_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        out_nxt    = out_cnt_q + 1'b1;
        case (state_q)
            S_LOAD: begin
                s_ready_d = 1'b1;
                if (s_valid && s_ready_q) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d  = '0;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b1;
                        step_d    = '0;
                        grp_d     = '0;
                        state_d   = S_COMPUTE;
                    end else begin
                        in_cnt_d = in_cnt_q + 1'b1;
                    end
                end
            end
            S_COMPUTE: begin
                if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (grp_q == GRP_LAST) begin
                        grp_d     = '0;
                        out_cnt_d = '0;
                        state_d   = S_DRAIN;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // One fill cycle after the last buffer write, then 1 element/cycle.
                if (!m_valid_q) begin
                    m_valid_d  = 1'b1;
                    data_out_d = y_mem[0];
                    out_cnt_d  = '0;
                end else if (m_ready) begin
                    if (out_cnt_q == OUT_LAST) begin
                        m_valid_d = 1'b0;
                        out_cnt_d = '0;
                        s_ready_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        out_cnt_d  = out_nxt;
                        data_out_d = y_mem[out_nxt];
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_LOAD;
            in_cnt_q   <= '0;
            step_q     <= '0;
            grp_q      <= '0;
            out_cnt_q  <= '0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_cnt_q   <= in_cnt_d;
            step_q     <= step_d;
            grp_q      <= grp_d;
            out_cnt_q  <= out_cnt_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
        end
    end

    // Storage arrays are deliberately outside reset so coefficients survive it.
    always_ff @(posedge clk) begin
        if (cfg_we && state_q == S_LOAD && {1'b0, cfg_addr} < NCOEF_W)
            coef_mem[cfg_addr] <= cfg_data;
        if (state_q == S_LOAD && s_valid && s_ready_q)
            x_mem[in_cnt_q] <= data_in;
        if (wr_rows)
            for (int k = 0; k < P; k++)
                y_mem[row_idx[k]] <= lane_y[k];
    end

    assign s_ready  = s_ready_q;
    assign m_valid  = m_valid_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_layer_mvm_par.sv
// Randomised bench for layer_mvm_par: four instances (P=2/1/4/8, mixed RELU) run the same
// scenarios one at a time against an arithmetic reference of y = act(sat(W*x + b)).

module tb_layer_mvm_par;
    localparam int N  = 8;
    localparam int M  = 8;
    localparam int T  = 12;
    localparam int ND = 4;
    localparam int NC = M * N + M;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           s_valid  [ND];
    logic           s_ready  [ND];
    logic           m_valid  [ND];
    logic           busy     [ND];
    logic           cfg_we   [ND];
    logic [T-1:0]   data_out [ND];
    logic [T-1:0]   data_in;
    logic [T-1:0]   cfg_data;
    logic [6:0]     cfg_addr;
    logic           m_ready;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int PG = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
        localparam int RG = (g == 0 || g == 3) ? 1 : 0;
        layer_mvm_par #(.N(N), .M(M), .T(T), .P(PG), .RELU(RG)) u_dut (
            .clk      (clk),
            .reset    (reset),
            .s_valid  (s_valid[g]),
            .s_ready  (s_ready[g]),
            .data_in  (data_in),
            .m_valid  (m_valid[g]),
            .m_ready  (m_ready),
            .data_out (data_out[g]),
            .cfg_we   (cfg_we[g]),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .busy     (busy[g])
        );
    end

    int n_vec = 0;
    int n_err = 0;
    int sel   = 0;
    int cw [ND][NC];
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    int cbuf [NC];
    int xv [N];

    function automatic int p_of(int d);
        case (d)
            0: return 2;
            1: return 1;
            2: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int relu_of(int d);
        return (d == 0 || d == 3) ? 1 : 0;
    endfunction

    function automatic int sx(logic [T-1:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(string tag, int got, int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0d expected %0d", tag, sel, got, exp);
        end
    endtask

    task automatic cfg_wr(int a, int v);
        @(negedge clk);
        cfg_we[sel] = 1'b1;
        cfg_addr    = a[6:0];
        cfg_data    = v[T-1:0];
        if (a < NC) cw[sel][a] = v;
    endtask

    task automatic cfg_end();
        @(negedge clk);
        cfg_we[sel] = 1'b0;
    endtask

    task automatic load_coefs();
        for (int a = 0; a < NC; a++) cfg_wr(a, cbuf[a]);
        cfg_end();
    endtask

    task automatic compute_exp(input int xs[N], output int e[M]);
        longint acc;
        for (int r = 0; r < M; r++) begin
            acc = cw[sel][M*N + r];
            for (int c = 0; c < N; c++) acc += longint'(cw[sel][r*N + c]) * xs[c];
            if (acc > 2047) acc = 2047;
            if (acc < -2048) acc = -2048;
            if (relu_of(sel) == 1 && acc < 0) acc = 0;
            e[r] = int'(acc);
        end
    endtask

    // smode: 0 = always ready, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
    task automatic run_vec(input int xs[N], input int gap, input int smode,
                           input bit mid_cfg, input bit mid_rst, input bit load_cfg);
        int i, k, j, cyc, pc, prev, nv;
        int e [M];
        int got [M];
        bit stalled, done_cfg, rdy;
        i = 0; cyc = 0; done_cfg = 0;
        while (i < N) begin
            @(negedge clk);
            if (cyc > 400) begin
                check("in_timeout", i, N);
                s_valid[sel] = 1'b0; cfg_we[sel] = 1'b0;
                return;
            end
            cyc++;
            s_valid[sel] = (gap == 0) || ($urandom_range(99) >= gap);
            data_in      = xs[i][T-1:0];
            if (load_cfg && !done_cfg && i == 2) begin
                nv = int'($urandom_range(4095)) - 2048;
                cfg_we[sel] = 1'b1;
                cfg_addr    = 7'(NC - 1);
                cfg_data    = nv[T-1:0];
                cw[sel][NC-1] = nv;
                done_cfg = 1;
            end else begin
                cfg_we[sel] = 1'b0;
            end
            if (s_valid[sel] && s_ready[sel]) i++;
        end
        compute_exp(xs, e);
        @(negedge clk);
        s_valid[sel] = 1'b0;
        cfg_we[sel]  = 1'b0;
        check("busy_rise", busy[sel], 1);
        check("s_ready_fall", s_ready[sel], 0);
        k = 0;
        while (!m_valid[sel]) begin
            if (k > 1000) begin
                check("lat_timeout", k, 0);
                return;
            end
            if (mid_rst && k == 5) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_m_valid", m_valid[sel], 0);
                check("rst_s_ready", s_ready[sel], 0);
                check("rst_busy", busy[sel], 0);
                reset = 1'b0;
                @(negedge clk);
                check("rst_s_ready_rise", s_ready[sel], 1);
                check("rst_no_output", m_valid[sel], 0);
                return;
            end
            if (mid_cfg && k == 3) begin
                nv = (cw[sel][0] > 0) ? cw[sel][0] - 1000 : cw[sel][0] + 1000;
                cfg_we[sel] = 1'b1;
                cfg_addr    = '0;
                cfg_data    = nv[T-1:0];
            end else begin
                cfg_we[sel] = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        cfg_we[sel] = 1'b0;
        check("latency", k, (M / p_of(sel)) * (N + 2) + 1);
        j = 0; cyc = 0; pc = 0; stalled = 0; prev = 0;
        while (j < M) begin
            if (cyc > 500) begin
                check("drain_timeout", j, M);
                m_ready = 1'b0;
                return;
            end
            cyc++;
            check("busy_drain", busy[sel], 1);
            check("s_ready_drain", s_ready[sel], 0);
            check("m_valid_hold", m_valid[sel], 1);
            if (stalled) check("stall_stable", sx(data_out[sel]), prev);
            case (smode)
                0: rdy = 1'b1;
                1: rdy = pat[pc % 6] != 0;
                default: rdy = $urandom_range(1) != 0;
            endcase
            pc++;
            m_ready = rdy;
            if (m_valid[sel] && rdy) begin
                got[j] = sx(data_out[sel]);
                j++;
                stalled = 0;
            end else begin
                stalled = 1;
                prev = sx(data_out[sel]);
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        check("m_valid_fall", m_valid[sel], 0);
        check("s_ready_rise", s_ready[sel], 1);
        check("busy_fall", busy[sel], 0);
        for (int r = 0; r < M; r++) check($sformatf("y%0d", r), got[r], e[r]);
    endtask

    function automatic int rnd(int lo, int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    initial begin
        int s;
        for (int d = 0; d < ND; d++) begin
            s_valid[d] = 1'b0;
            cfg_we[d]  = 1'b0;
        end
        m_ready = 1'b0; data_in = '0; cfg_data = '0; cfg_addr = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            sel = d;
            check("reset_s_ready", s_ready[d], 0);
            check("reset_m_valid", m_valid[d], 0);
            check("reset_data_out", sx(data_out[d]), 0);
            check("reset_busy", busy[d], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            sel = d;
            check("reset_release_s_ready", s_ready[d], 1);
        end

        for (int d = 0; d < ND; d++) begin
            sel = d;
            // identity
            for (int a = 0; a < NC; a++) cbuf[a] = (a < M*N && (a / N) == (a % N)) ? 1 : 0;
            load_coefs();
            for (int c = 0; c < N; c++) xv[c] = c + 1;
            run_vec(xv, 0, 0, 0, 0, 0);
            // constant negative bias
            for (int a = 0; a < NC; a++) cbuf[a] = (a < M*N) ? 0 : -5;
            load_coefs();
            for (int c = 0; c < N; c++) xv[c] = rnd(-2048, 2047);
            run_vec(xv, 0, 0, 0, 0, 0);
            // ramp bias
            for (int a = 0; a < NC; a++) cbuf[a] = (a < M*N) ? 0 : a - M*N;
            load_coefs();
            run_vec(xv, 0, 0, 0, 0, 0);
            // positive and negative saturation
            for (int a = 0; a < NC; a++) cbuf[a] = (a < M*N) ? 2047 : 0;
            load_coefs();
            for (int c = 0; c < N; c++) xv[c] = 2047;
            run_vec(xv, 0, 0, 0, 0, 0);
            for (int a = 0; a < NC; a++) cbuf[a] = (a < M*N) ? -2048 : 0;
            load_coefs();
            run_vec(xv, 0, 0, 0, 0, 0);
            // mixed signs with bias chosen so each row sums to 100
            for (int c = 0; c < N; c++) xv[c] = rnd(-10, 10);
            for (int r = 0; r < M; r++) begin
                s = 0;
                for (int c = 0; c < N; c++) begin
                    cbuf[r*N + c] = rnd(-10, 10);
                    s += cbuf[r*N + c] * xv[c];
                end
                cbuf[M*N + r] = 100 - s;
            end
            load_coefs();
            run_vec(xv, 0, 0, 0, 0, 0);
            // random coefficients, input gaps and output backpressure
            for (int a = 0; a < NC; a++) cbuf[a] = rnd(-2048, 2047);
            load_coefs();
            for (int c = 0; c < N; c++) xv[c] = rnd(-64, 63);
            run_vec(xv, 30, 1, 0, 0, 0);
            for (int c = 0; c < N; c++) xv[c] = rnd(-64, 63);
            run_vec(xv, 40, 2, 0, 0, 1);
            // out-of-range and mid-compute writes are dropped
            for (int c = 0; c < N; c++) xv[c] = rnd(1, 63);
            cfg_wr(72, 1234);
            cfg_end();
            run_vec(xv, 0, 0, 1, 0, 0);
            // the same write made in LOAD is honoured
            cfg_wr(0, (cw[d][0] > 0) ? cw[d][0] - 1000 : cw[d][0] + 1000);
            cfg_end();
            run_vec(xv, 0, 2, 0, 0, 0);
            // reset during COMPUTE, then a fresh vector on retained coefficients
            for (int c = 0; c < N; c++) xv[c] = rnd(-64, 63);
            run_vec(xv, 0, 0, 0, 1, 0);
            for (int c = 0; c < N; c++) xv[c] = rnd(-64, 63);
            run_vec(xv, 20, 2, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/layer_mvm_par.md
# layer_mvm_par

Parametrised fully-connected layer engine and successor to the fixed 8x8 ROM-based layer generators. It takes an N-element signed input vector over a valid/ready stream and computes y = act(W·x + b) for M outputs, using P parallel MAC lanes. Weights and biases live in a run-time-writable RAM, and it streams M saturated results out over a second valid/ready stream. It sits between a vector producer (previous layer or testbench) and a result consumer.

## Interface
- N, 8, input vector length (≥1)
- M, 8, output vector length (≥1; M % P == 0)
- T, 12, signed data width of x, W, b, y
- P, 2, parallel MAC lanes
- RELU, 1, 1 = clamp negative results to 0; 0 = pass through
- CAW, $clog2(M*N+M), cfg address width (derived)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  asynchronous, active-high; clears control state
- s_valid  in  1  input element valid
- s_ready  out  1  block can accept an input element
- data_in  in  T  signed input element x[i], in order i = 0..N-1
- m_valid  out  1  output element valid
- m_ready  in  1  consumer accepts output element
- data_out  out  T  signed result y[j], in order j = 0..M-1
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  CAW  address in [0, M*N): W[r][c] at r*N+c; address in [M*N, M*N+M): b[addr−M*N]
- cfg_data  in  T  coefficient value
- busy  out  1  high in COMPUTE and DRAIN

## Operation
- A transfer occurs on a posedge where valid && ready. All outputs are registered.
- States: LOAD → COMPUTE → DRAIN → LOAD.
- **LOAD.** s_ready = 1 while fewer than N elements have been accepted. Each accepted element is stored at x[count]. On the edge that accepts the N-th element, s_ready ← 0 and the FSM enters COMPUTE.
- **COMPUTE.** Rows are processed in M/P groups. Lane k of group g computes row g*P+k.
  - The accumulator preloads the bias, then adds W[r][c]·x[c] for c = 0..N−1.
  - Product width is 2T. Accumulator width is 2T+$clog2(N)+1, so there is no internal overflow.
  - On completion, each result is saturated to [−2^(T−1), 2^(T−1)−1], then ReLU is applied if RELU=1, then it is written to the output buffer at index r.
- **DRAIN.** Outputs y[0..M−1] are presented in order. data_out is held stable while m_valid && !m_ready. Throughput is 1 element/cycle when m_ready is held high. On the M-th transfer, m_valid ← 0 and the FSM enters LOAD.
- **Cfg writes.**
  - Honoured only in LOAD.
  - Writes in COMPUTE/DRAIN are dropped.
  - Addresses ≥ M*N+M are dropped.
  - A cfg write and an s_valid transfer in the same cycle are both honoured.
- Coefficient RAM and x buffer are not cleared by reset. The contents are retained across reset.

## Timing
- **Reset values:** s_ready=0, m_valid=0, data_out=0, busy=0, FSM=LOAD, all counters 0. s_ready rises on the first posedge after reset deasserts.
- **Reset mid-operation** (any state) abandons the vector immediately. No partial outputs are emitted afterwards.
- **Latency:** m_valid first rises exactly (M/P)*(N+2)+1 cycles after the edge accepting x[N−1]. The +2 per group covers the bias preload and the multiply pipeline stage.
- busy rises on the edge accepting x[N−1] and falls on the edge of the M-th output transfer.
- s_ready rises on the same edge that m_valid falls, after the last output transfer.
- The first input of the next vector may transfer on the following edge.
- **Wrap-around:** element and output counters return to 0 after N and M respectively. No element is accepted beyond N per vector.

## Test plan
- **Identity.** Defaults. Load W=I and b=0; send x=1..8 with s_valid held high. Required: y=1..8; m_valid rises 41 cycles after the last input; busy tracks COMPUTE/DRAIN.
- **Bias/ReLU.**
  - W=0, b=−5, any x. RELU=1 → all y=0; RELU=0 → all y=−5.
  - W=0, b[j]=j → y=0..7.
- **Saturation** (RELU=0).
  - All W=2047, x=2047 → every y=2047.
  - All W=−2048, x=2047 → every y=−2048.
  - Mixed signs summing to 100 → y=100.
- **Backpressure.** m_ready pattern 1,0,0,1,0,1… Required: data_out stable during stalls; exactly 8 transfers, in order; s_ready returns only after the 8th transfer. s_valid gaps during LOAD must not change results.
- **Cfg protection.**
  - cfg_we to W[0][0] during COMPUTE, and to address 72, are both ignored: results are unchanged.
  - The same W[0][0] write during LOAD takes effect on the next vector.
- **Reset mid-COMPUTE**, then a new vector. Required: m_valid=0 and s_ready=0 during reset; correct results using the retained coefficients. Repeat all scenarios for P=1, 4, 8: results must be identical and latency must follow the formula.
